// File: rtl/id_exe_stage_reg.sv
// ---------------------------------------------------------------------------
// id_exe_stage_reg
//   ID->EXE pipeline register of the ARM 5-stage core. It captures the control
//   bundle (S, B, EXE_CMD, MEM_W_EN, MEM_R_EN, WB_EN) and the decoded operands
//   and fields from ID, and presents them to EXE one cycle later. It also keeps
//   saturating performance counters for bubbles and flushes.
//
//   Per-edge priority: hold > flush > bubble > load.
//
// Ports
//   clk, rst_n           core clock, asynchronous active-low reset
//   hold                 global stall: every output keeps its value
//   flush                taken branch: squash the ID instruction (NOP into EXE)
//   bubble               hazard: insert a NOP into EXE
//   cnt_clr              synchronous clear of both counters (works during hold)
//   id_valid             ID holds a real instruction
//   id_*                 control bundle and decoded operands from ID
//   exe_*                registered copy of every id_* input
//   exe_valid            EXE holds a real instruction
//   bubble_cnt           cycles in which a bubble replaced a valid instruction
//   flush_cnt            cycles in which a flush squashed a valid instruction
// ---------------------------------------------------------------------------
module id_exe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic              bubble,
  input  logic              cnt_clr,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic              id_s,
  input  logic              id_b,
  input  logic [3:0]        id_exe_cmd,
  input  logic              id_mem_w_en,
  input  logic              id_mem_r_en,
  input  logic              id_wb_en,
  input  logic [DATA_W-1:0] id_val_rn,
  input  logic [DATA_W-1:0] id_val_rm,
  input  logic              id_imm,
  input  logic [11:0]       id_shift_op,
  input  logic [23:0]       id_simm24,
  input  logic [3:0]        id_dest,
  input  logic [3:0]        id_src1,
  input  logic [3:0]        id_src2,
  input  logic [3:0]        id_status,
  output logic [DATA_W-1:0] exe_pc,
  output logic              exe_s,
  output logic              exe_b,
  output logic [3:0]        exe_exe_cmd,
  output logic              exe_mem_w_en,
  output logic              exe_mem_r_en,
  output logic              exe_wb_en,
  output logic [DATA_W-1:0] exe_val_rn,
  output logic [DATA_W-1:0] exe_val_rm,
  output logic              exe_imm,
  output logic [11:0]       exe_shift_op,
  output logic [23:0]       exe_simm24,
  output logic [3:0]        exe_dest,
  output logic [3:0]        exe_src1,
  output logic [3:0]        exe_src2,
  output logic [3:0]        exe_status,
  output logic              exe_valid,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // A NOP is forced whenever flush or bubble wins over a plain load.
  logic squash;
  logic flush_inc;
  logic bubble_inc;

  assign squash     = flush | bubble;
  // Counters only count cycles in which a real instruction was thrown away.
  assign flush_inc  = !hold && flush && id_valid;
  assign bubble_inc = !hold && !flush && bubble && id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_pc       <= '0;
      exe_s        <= 1'b0;
      exe_b        <= 1'b0;
      exe_exe_cmd  <= '0;
      exe_mem_w_en <= 1'b0;
      exe_mem_r_en <= 1'b0;
      exe_wb_en    <= 1'b0;
      exe_val_rn   <= '0;
      exe_val_rm   <= '0;
      exe_imm      <= 1'b0;
      exe_shift_op <= '0;
      exe_simm24   <= '0;
      exe_dest     <= '0;
      exe_src1     <= '0;
      exe_src2     <= '0;
      exe_status   <= '0;
      exe_valid    <= 1'b0;
    end else if (!hold) begin
      if (squash) begin
        exe_pc       <= '0;
        exe_s        <= 1'b0;
        exe_b        <= 1'b0;
        exe_exe_cmd  <= '0;
        exe_mem_w_en <= 1'b0;
        exe_mem_r_en <= 1'b0;
        exe_wb_en    <= 1'b0;
        exe_val_rn   <= '0;
        exe_val_rm   <= '0;
        exe_imm      <= 1'b0;
        exe_shift_op <= '0;
        exe_simm24   <= '0;
        exe_dest     <= '0;
        exe_src1     <= '0;
        exe_src2     <= '0;
        exe_status   <= '0;
        exe_valid    <= 1'b0;
      end else begin
        exe_pc       <= id_pc;
        // Side-effecting control bits never leave ID for an invalid slot, so a
        // stray decode of garbage cannot write memory, registers or flags.
        exe_s        <= id_s        & id_valid;
        exe_b        <= id_b        & id_valid;
        exe_exe_cmd  <= id_exe_cmd;
        exe_mem_w_en <= id_mem_w_en & id_valid;
        exe_mem_r_en <= id_mem_r_en & id_valid;
        exe_wb_en    <= id_wb_en    & id_valid;
        exe_val_rn   <= id_val_rn;
        exe_val_rm   <= id_val_rm;
        exe_imm      <= id_imm;
        exe_shift_op <= id_shift_op;
        exe_simm24   <= id_simm24;
        exe_dest     <= id_dest;
        exe_src1     <= id_src1;
        exe_src2     <= id_src2;
        exe_status   <= id_status;
        exe_valid    <= id_valid;
      end
    end
  end

  // cnt_clr is checked ahead of hold and ahead of any increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (cnt_clr) begin
      flush_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (flush_inc && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
      if (bubble_inc && (bubble_cnt != CNT_MAX)) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_exe_stage_reg.sv
module tb_id_exe_stage_reg;

  localparam int DATA_W = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold, flush, bubble, cnt_clr, id_valid;
  logic [31:0] id_pc, id_val_rn, id_val_rm;
  logic        id_s, id_b, id_mem_w_en, id_mem_r_en, id_wb_en, id_imm;
  logic [3:0]  id_exe_cmd, id_dest, id_src1, id_src2, id_status;
  logic [11:0] id_shift_op;
  logic [23:0] id_simm24;

  logic [31:0] exe_pc, exe_val_rn, exe_val_rm;
  logic        exe_s, exe_b, exe_mem_w_en, exe_mem_r_en, exe_wb_en, exe_imm, exe_valid;
  logic [3:0]  exe_exe_cmd, exe_dest, exe_src1, exe_src2, exe_status;
  logic [11:0] exe_shift_op;
  logic [23:0] exe_simm24;
  logic [15:0] bubble_cnt, flush_cnt;

  // second instance with narrow counters for the saturation check
  logic [31:0] e4_pc, e4_val_rn, e4_val_rm;
  logic        e4_s, e4_b, e4_mem_w_en, e4_mem_r_en, e4_wb_en, e4_imm, e4_valid;
  logic [3:0]  e4_exe_cmd, e4_dest, e4_src1, e4_src2, e4_status;
  logic [11:0] e4_shift_op;
  logic [23:0] e4_simm24;
  logic [3:0]  bubble_cnt4, flush_cnt4;

  always #5 clk = ~clk;

  id_exe_stage_reg #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .bubble(bubble),
    .cnt_clr(cnt_clr), .id_valid(id_valid), .id_pc(id_pc), .id_s(id_s), .id_b(id_b),
    .id_exe_cmd(id_exe_cmd), .id_mem_w_en(id_mem_w_en), .id_mem_r_en(id_mem_r_en),
    .id_wb_en(id_wb_en), .id_val_rn(id_val_rn), .id_val_rm(id_val_rm), .id_imm(id_imm),
    .id_shift_op(id_shift_op), .id_simm24(id_simm24), .id_dest(id_dest),
    .id_src1(id_src1), .id_src2(id_src2), .id_status(id_status),
    .exe_pc(exe_pc), .exe_s(exe_s), .exe_b(exe_b), .exe_exe_cmd(exe_exe_cmd),
    .exe_mem_w_en(exe_mem_w_en), .exe_mem_r_en(exe_mem_r_en), .exe_wb_en(exe_wb_en),
    .exe_val_rn(exe_val_rn), .exe_val_rm(exe_val_rm), .exe_imm(exe_imm),
    .exe_shift_op(exe_shift_op), .exe_simm24(exe_simm24), .exe_dest(exe_dest),
    .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_status(exe_status),
    .exe_valid(exe_valid), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  id_exe_stage_reg #(.DATA_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .bubble(bubble),
    .cnt_clr(cnt_clr), .id_valid(id_valid), .id_pc(id_pc), .id_s(id_s), .id_b(id_b),
    .id_exe_cmd(id_exe_cmd), .id_mem_w_en(id_mem_w_en), .id_mem_r_en(id_mem_r_en),
    .id_wb_en(id_wb_en), .id_val_rn(id_val_rn), .id_val_rm(id_val_rm), .id_imm(id_imm),
    .id_shift_op(id_shift_op), .id_simm24(id_simm24), .id_dest(id_dest),
    .id_src1(id_src1), .id_src2(id_src2), .id_status(id_status),
    .exe_pc(e4_pc), .exe_s(e4_s), .exe_b(e4_b), .exe_exe_cmd(e4_exe_cmd),
    .exe_mem_w_en(e4_mem_w_en), .exe_mem_r_en(e4_mem_r_en), .exe_wb_en(e4_wb_en),
    .exe_val_rn(e4_val_rn), .exe_val_rm(e4_val_rm), .exe_imm(e4_imm),
    .exe_shift_op(e4_shift_op), .exe_simm24(e4_simm24), .exe_dest(e4_dest),
    .exe_src1(e4_src1), .exe_src2(e4_src2), .exe_status(e4_status),
    .exe_valid(e4_valid), .bubble_cnt(bubble_cnt4), .flush_cnt(flush_cnt4)
  );

  // Every exe_* field in one vector, fixed order, for whole-bundle comparison.
  logic [157:0] obs_vec, obs4_vec;
  assign obs_vec = {exe_pc, exe_s, exe_b, exe_exe_cmd, exe_mem_w_en, exe_mem_r_en,
                    exe_wb_en, exe_val_rn, exe_val_rm, exe_imm, exe_shift_op,
                    exe_simm24, exe_dest, exe_src1, exe_src2, exe_status};
  assign obs4_vec = {e4_pc, e4_s, e4_b, e4_exe_cmd, e4_mem_w_en, e4_mem_r_en,
                     e4_wb_en, e4_val_rn, e4_val_rm, e4_imm, e4_shift_op,
                     e4_simm24, e4_dest, e4_src1, e4_src2, e4_status};

  // Reference model state
  logic [157:0] exp_vec;
  logic         exp_valid;
  int           exp_fc, exp_bc, exp_bc4, exp_fc4;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ID bundle as EXE should see it after a plain load.
  function automatic logic [157:0] id_bundle();
    logic g;
    g = id_valid;
    return {id_pc, id_s & g, id_b & g, id_exe_cmd, id_mem_w_en & g, id_mem_r_en & g,
            id_wb_en & g, id_val_rn, id_val_rm, id_imm, id_shift_op, id_simm24,
            id_dest, id_src1, id_src2, id_status};
  endfunction

  function automatic int sat_inc(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  task automatic model_reset();
    exp_vec = '0; exp_valid = 1'b0;
    exp_fc = 0; exp_bc = 0; exp_fc4 = 0; exp_bc4 = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".exe"},   {2'b0, obs_vec},  {2'b0, exp_vec});
    chk({tag, ".valid"}, {159'b0, exe_valid}, {159'b0, exp_valid});
    chk({tag, ".fcnt"},  {144'b0, flush_cnt},  160'(exp_fc));
    chk({tag, ".bcnt"},  {144'b0, bubble_cnt}, 160'(exp_bc));
    chk({tag, ".exe4"},  {2'b0, obs4_vec}, {2'b0, exp_vec});
    chk({tag, ".fcnt4"}, {156'b0, flush_cnt4},  160'(exp_fc4));
    chk({tag, ".bcnt4"}, {156'b0, bubble_cnt4}, 160'(exp_bc4));
  endtask

  // Advance one clock edge with the inputs currently applied.
  task automatic step(input string tag);
    if (!hold) begin
      if (flush || bubble) begin
        exp_vec = '0; exp_valid = 1'b0;
      end else begin
        exp_vec = id_bundle(); exp_valid = id_valid;
      end
    end
    if (cnt_clr) begin
      exp_fc = 0; exp_bc = 0; exp_fc4 = 0; exp_bc4 = 0;
    end else if (!hold && id_valid) begin
      if (flush) begin
        exp_fc = sat_inc(exp_fc, 65535); exp_fc4 = sat_inc(exp_fc4, 15);
      end else if (bubble) begin
        exp_bc = sat_inc(exp_bc, 65535); exp_bc4 = sat_inc(exp_bc4, 15);
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic rand_data();
    id_pc = $urandom; id_val_rn = $urandom; id_val_rm = $urandom;
    id_s = 1'($urandom); id_b = 1'($urandom); id_mem_w_en = 1'($urandom);
    id_mem_r_en = 1'($urandom); id_wb_en = 1'($urandom); id_imm = 1'($urandom);
    id_exe_cmd = 4'($urandom); id_dest = 4'($urandom); id_src1 = 4'($urandom);
    id_src2 = 4'($urandom); id_status = 4'($urandom);
    id_shift_op = 12'($urandom); id_simm24 = 24'($urandom);
  endtask

  task automatic ctrl(input logic h, input logic f, input logic b, input logic c, input logic v);
    hold = h; flush = f; bubble = b; cnt_clr = c; id_valid = v;
  endtask

  initial begin
    rst_n = 1'b0;
    ctrl(0, 0, 0, 0, 0);
    rand_data();
    model_reset();
    #2;
    check_all("reset_init");
    #10 rst_n = 1'b1;                       // released between edges

    // T2: basic load
    ctrl(0, 0, 0, 0, 1); rand_data();
    id_exe_cmd = 4'b0010; id_wb_en = 1'b1; id_val_rn = 32'h10; id_dest = 4'd3;
    step("t2_load");
    chk("t2_cmd",  160'(exe_exe_cmd), 160'(4'b0010));
    chk("t2_rn",   160'(exe_val_rn),  160'(32'h10));
    chk("t2_dest", 160'(exe_dest),    160'(4'd3));
    chk("t2_wb",   160'(exe_wb_en),   160'(1'b1));

    // T1: asynchronous reset mid-cycle while exe_wb_en=1
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t1_async_reset");
    #2 rst_n = 1'b1;
    ctrl(0, 0, 0, 0, 1); rand_data();
    step("t1_first_after_release");

    // T3: hold for 3 cycles with changing inputs, then release
    for (int i = 0; i < 3; i++) begin
      ctrl(1, 1'($urandom), 1'($urandom), 0, 1); rand_data();
      step("t3_hold");
    end
    ctrl(0, 0, 0, 0, 1); rand_data();
    step("t3_release");

    // T4: flush + bubble together, then hold + flush
    ctrl(0, 0, 0, 1, 0); step("t4_clr");
    ctrl(0, 1, 1, 0, 1); rand_data(); step("t4_flush_bubble");
    chk("t4_fcnt_one", 160'(flush_cnt),  160'(16'd1));
    chk("t4_bcnt_zero", 160'(bubble_cnt), 160'(16'd0));
    ctrl(0, 0, 0, 0, 1); rand_data(); step("t4_reload");
    ctrl(1, 1, 0, 0, 1); rand_data(); step("t4_hold_flush");

    // cnt_clr works during hold
    ctrl(0, 1, 0, 0, 1); step("t4_flush2");
    ctrl(1, 0, 0, 1, 1); step("clr_in_hold");

    // T5: 17 bubbles saturate the 4-bit counter; clear beats increment
    for (int i = 0; i < 17; i++) begin
      ctrl(0, 0, 1, 0, 1); rand_data(); step("t5_bubble");
    end
    chk("t5_sat", 160'(bubble_cnt4), 160'(4'hF));
    chk("t5_wide", 160'(bubble_cnt), 160'(16'd17));
    ctrl(0, 0, 1, 1, 1); step("t5_clr_bubble");
    chk("t5_clr", 160'(bubble_cnt4), 160'(4'h0));

    // T6: invalid slot gates control bits, data passes
    ctrl(0, 0, 0, 0, 0); rand_data();
    id_mem_w_en = 1'b1; id_val_rm = 32'hABCD;
    step("t6_invalid");
    chk("t6_memw",  160'(exe_mem_w_en), 160'(1'b0));
    chk("t6_valid", 160'(exe_valid),    160'(1'b0));
    chk("t6_rm",    160'(exe_val_rm),   160'(32'hABCD));

    // Random phase
    for (int i = 0; i < 400; i++) begin
      ctrl(($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 10),
           ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 99) < 75));
      rand_data();
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
